// File: rtl/sop_approx_pkg.sv
// Shared types and helpers for the approximate absolute-difference datapath.
// MAX_W is the widest operand the pipeline supports. Payload fields are sized to
// it, and each instance keeps only its low WIDTH bits (WIDTH must be below MAX_W).
package sop_approx_pkg;

    localparam int MAX_W = 32;

    // Stage-1 payload: operands, precomputed borrow (a < b) and the mode bit.
    typedef struct packed {
        logic [MAX_W-1:0] a;
        logic [MAX_W-1:0] b;
        logic             borrow;
        logic             approx;
    } s1_payload_t;

    // Keep-mask: ones on bits [width-1:trunc], zeros on the truncated LSBs.
    function automatic logic [MAX_W-1:0] trunc_mask(input int width, input int trunc);
        logic [MAX_W-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i >= trunc && i < width) m[i] = 1'b1;
        end
        return m;
    endfunction

    // Unsigned |a - b|.
    function automatic logic [MAX_W-1:0] abs_diff(input logic [MAX_W-1:0] a,
                                                  input logic [MAX_W-1:0] b);
        return (a < b) ? (b - a) : (a - b);
    endfunction

endpackage

// File: rtl/sop_abs_diff_core.sv
// Combinational core of stage 2: the exact |a-b| is formed from the registered
// borrow. The approximate result clears the TRUNC LSBs when the beat asks for it.
module sop_abs_diff_core
    import sop_approx_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int TRUNC = 1
) (
    input  s1_payload_t      payload,
    output logic [WIDTH-1:0] exact,
    output logic [WIDTH-1:0] result
);

    localparam logic [MAX_W-1:0] KEEP_W = trunc_mask(WIDTH, TRUNC);
    localparam logic [WIDTH-1:0] KEEP   = KEEP_W[WIDTH-1:0];

    logic [MAX_W-1:0] diff_w;
    logic             unused_hi;

    // Subtract in the order the borrow selected so the result never wraps.
    always_comb begin
        diff_w = payload.borrow ? (payload.b - payload.a) : (payload.a - payload.b);
    end

    assign exact     = diff_w[WIDTH-1:0];
    assign unused_hi = ^diff_w[MAX_W-1:WIDTH];
    assign result    = payload.approx ? (exact & KEEP) : exact;

endmodule

// File: rtl/sop_abs_diff_pipe.sv
// Two-stage pipelined approximate absolute-difference unit with valid/ready on
// both sides. Optional error monitor: define SOP_ABS_DIFF_ERR_MONITOR_EN to
// count approximate results whose error (exact - delivered) exceeds ET.
// Without the macro err_cnt/err_flag are tied to 0 and err_clr is ignored.
//
// Handshake: a beat moves on a port when valid && ready are both high at the
// rising edge. A producer holds valid and data until accepted. While out_valid
// is high and out_ready low, out_diff is held unchanged.
module sop_abs_diff_pipe
    import sop_approx_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int TRUNC     = 1,
    parameter int ET        = 1,
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_approx,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_diff,
    input  logic                 err_clr,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 err_flag
);

    logic             ready_en;
    logic             s1_valid;
    s1_payload_t      s1;
    logic             s2_valid;
    logic [WIDTH-1:0] s2_diff;
    logic             s1_advance;
    logic             in_fire;
    logic             out_fire;
    logic [WIDTH-1:0] core_exact;
    logic [WIDTH-1:0] core_result;

    // S2 moves when empty or draining; S1 then advances into it.
    assign out_fire   = s2_valid && out_ready;
    assign s1_advance = !s2_valid || out_ready;
    assign in_ready   = ready_en && (!s1_valid || s1_advance);
    assign in_fire    = in_valid && in_ready;
    assign out_valid  = s2_valid;
    assign out_diff   = s2_diff;

    // Holds in_ready low through reset and opens it the cycle after release.
    always_ff @(posedge clk) begin
        if (rst) ready_en <= 1'b0;
        else     ready_en <= 1'b1;
    end

    // Stage 1: capture operands, borrow and mode on each accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1       <= '0;
        end else begin
            if (!s1_valid || s1_advance) s1_valid <= in_fire;
            if (in_fire) begin
                s1 <= '{a:      MAX_W'(in_a),
                        b:      MAX_W'(in_b),
                        borrow: (in_a < in_b),
                        approx: in_approx};
            end
        end
    end

    sop_abs_diff_core #(
        .WIDTH (WIDTH),
        .TRUNC (TRUNC)
    ) u_core (
        .payload (s1),
        .exact   (core_exact),
        .result  (core_result)
    );

    // Stage 2: register the selected result; hold it while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_diff  <= '0;
        end else if (s1_advance) begin
            s2_valid <= s1_valid;
            if (s1_valid) s2_diff <= core_result;
        end
    end

`ifdef SOP_ABS_DIFF_ERR_MONITOR_EN
    localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;
    localparam int unsigned          ET_U    = ET;

    logic [WIDTH-1:0] s2_err;
    logic             s2_approx;
    logic             flagged;

    // Error travels alongside the result so it is judged at delivery time.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_err    <= '0;
            s2_approx <= 1'b0;
        end else if (s1_advance && s1_valid) begin
            s2_err    <= core_exact - core_result;
            s2_approx <= s1.approx;
        end
    end

    assign flagged = out_fire && s2_approx && (32'(s2_err) > ET_U);

    // Saturating count and sticky flag; a clear beats a same-cycle event.
    always_ff @(posedge clk) begin
        if (rst || err_clr) begin
            err_cnt  <= '0;
            err_flag <= 1'b0;
        end else if (flagged) begin
            err_flag <= 1'b1;
            if (err_cnt != CNT_MAX) err_cnt <= err_cnt + 1'b1;
        end
    end
`else
    logic unused_mon;

    assign err_cnt    = '0;
    assign err_flag   = 1'b0;
    assign unused_mon = ^{err_clr, core_exact, out_fire};
`endif

endmodule

// File: tb/tb_sop_abs_diff_pipe.sv
// Self-checking bench for sop_abs_diff_pipe (WIDTH=4, TRUNC=1, ET=0, ERR_CNT_W=3).
// Expected results come from plain integer arithmetic on the operands.
module tb_sop_abs_diff_pipe;

    localparam int WIDTH     = 4;
    localparam int TRUNC     = 1;
    localparam int ET        = 0;
    localparam int ERR_CNT_W = 3;
    localparam int CNT_MAX   = (1 << ERR_CNT_W) - 1;
`ifdef SOP_ABS_DIFF_ERR_MONITOR_EN
    localparam bit MON_EN = 1'b1;
`else
    localparam bit MON_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a = '0;
    logic [WIDTH-1:0]     in_b = '0;
    logic                 in_approx = 1'b0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [WIDTH-1:0]     out_diff;
    logic                 err_clr = 1'b0;
    logic [ERR_CNT_W-1:0] err_cnt;
    logic                 err_flag;

    sop_abs_diff_pipe #(
        .WIDTH     (WIDTH),
        .TRUNC     (TRUNC),
        .ET        (ET),
        .ERR_CNT_W (ERR_CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_approx (in_approx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_diff  (out_diff),
        .err_clr   (err_clr),
        .err_cnt   (err_cnt),
        .err_flag  (err_flag)
    );

    // ---------------- scoreboard / model ----------------
    int               n_checks = 0;
    int               n_fail   = 0;
    logic [WIDTH-1:0] exp_q[$];
    bit               flag_q[$];
    int               m_cnt  = 0;
    bit               m_flag = 1'b0;

    function automatic void model_push(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                       input logic ap);
        int ex;
        int res;
        ex  = (a >= b) ? (int'(a) - int'(b)) : (int'(b) - int'(a));
        res = ap ? (ex / (1 << TRUNC)) * (1 << TRUNC) : ex;
        exp_q.push_back(WIDTH'(res));
        flag_q.push_back(ap && ((ex - res) > ET));
    endfunction

    function automatic void model_mon(input bit flagged, input bit clr);
        if (!MON_EN) return;
        if (clr) begin
            m_cnt  = 0;
            m_flag = 1'b0;
        end else if (flagged) begin
            if (m_cnt < CNT_MAX) m_cnt++;
            m_flag = 1'b1;
        end
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        flag_q.delete();
        m_cnt  = 0;
        m_flag = 1'b0;
    endfunction

    // ---------------- driver ----------------
    // Drives all inputs on the falling edge; returns 1 ns later with outputs settled.
    task automatic step(input logic r, input logic v, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic ap, input logic ordy,
                        input logic clr);
        @(negedge clk);
        rst       = r;
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_approx = ap;
        out_ready = ordy;
        err_clr   = clr;
        #1;
    endtask

    // Book-keeping for the transfers that the coming rising edge will perform.
    task automatic book();
        bit fl;
        fl = 1'b0;
        if (out_valid && out_ready && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            fl = flag_q.pop_front();
        end
        model_mon(fl, err_clr);
        if (in_valid && in_ready) model_push(in_a, in_b, in_approx);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 1, 0);
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_checks++; if (out_diff !== '0) begin n_fail++; $display("FAIL reset_out_diff got=%0d exp=0", out_diff); end
        n_checks++; if (err_cnt !== '0) begin n_fail++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
        n_checks++; if (err_flag !== 1'b0) begin n_fail++; $display("FAIL reset_err_flag got=%b exp=0", err_flag); end
        step(0, 0, 0, 0, 0, 1, 0);
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL release_in_ready_early got=%b exp=0", in_ready); end
        step(0, 0, 0, 0, 0, 1, 0);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
        model_reset();
    endtask

    task automatic test_directed();
        logic [WIDTH-1:0] ta[8]  = '{4'd9, 4'd9, 4'd2, 4'd5, 4'd5, 4'd15, 4'd15, 4'd0};
        logic [WIDTH-1:0] tb_[8] = '{4'd2, 4'd2, 4'd9, 4'd5, 4'd5, 4'd0,  4'd0,  4'd15};
        logic             tap[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,  1'b1,  1'b1};
        logic [WIDTH-1:0] texp[8] = '{4'd6, 4'd7, 4'd7, 4'd0, 4'd0, 4'd15, 4'd14, 4'd14};
        for (int k = 0; k < 8; k++) begin
            step(0, 1, ta[k], tb_[k], tap[k], 1, 0);
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL dir%0d_in_ready got=%b exp=1", k, in_ready); end
            book();
            step(0, 0, 0, 0, 0, 1, 0);
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL dir%0d_early_valid got=%b exp=0", k, out_valid); end
            book();
            step(0, 0, 0, 0, 0, 1, 0);
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL dir%0d_latency got=%b exp=1", k, out_valid); end
            n_checks++; if (out_diff !== texp[k]) begin n_fail++; $display("FAIL dir%0d_diff a=%0d b=%0d ap=%b got=%0d exp=%0d", k, ta[k], tb_[k], tap[k], out_diff, texp[k]); end
            n_checks++; if (err_cnt !== ERR_CNT_W'(m_cnt)) begin n_fail++; $display("FAIL dir%0d_err_cnt got=%0d exp=%0d", k, err_cnt, m_cnt); end
            book();
        end
        step(0, 0, 0, 0, 0, 1, 0);
        n_checks++; if (err_flag !== m_flag) begin n_fail++; $display("FAIL dir_err_flag got=%b exp=%b", err_flag, m_flag); end
        n_checks++; if (err_cnt !== ERR_CNT_W'(m_cnt)) begin n_fail++; $display("FAIL dir_err_cnt got=%0d exp=%0d", err_cnt, m_cnt); end
        book();
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int got  = 0;
        logic ordy;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            ordy = !(cyc >= 3 && cyc <= 6);
            step(0, sent < 8, 4'(($urandom_range(0, 15))), 4'(($urandom_range(0, 15))),
                 1'($urandom_range(0, 1)), ordy, 0);
            if (cyc >= 3 && cyc <= 6) begin
                n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_in_ready cyc=%0d got=%b exp=0", cyc, in_ready); end
                n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_hold_valid cyc=%0d got=%b exp=1", cyc, out_valid); end
            end
            if (out_valid) begin
                n_checks++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL b2b_spurious cyc=%0d got=%0d exp=none", cyc, out_diff); end
                else if (out_diff !== exp_q[0]) begin n_fail++; $display("FAIL b2b_data cyc=%0d got=%0d exp=%0d", cyc, out_diff, exp_q[0]); end
            end
            if (out_valid && out_ready) got++;
            if (in_valid && in_ready) sent++;
            book();
        end
        n_checks++; if (got !== 8) begin n_fail++; $display("FAIL b2b_count got=%0d exp=8", got); end
        n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL b2b_leftover got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_random_stream();
        for (int cyc = 0; cyc < 320; cyc++) begin
            if (cyc < 300)
                step(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                     1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
            else
                step(0, 0, 0, 0, 0, 1, 0);
            if (out_valid) begin
                n_checks++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL rnd_spurious cyc=%0d got=%0d exp=none", cyc, out_diff); end
                else if (out_diff !== exp_q[0]) begin n_fail++; $display("FAIL rnd_data cyc=%0d got=%0d exp=%0d", cyc, out_diff, exp_q[0]); end
            end
            n_checks++; if (err_cnt !== ERR_CNT_W'(m_cnt)) begin n_fail++; $display("FAIL rnd_err_cnt cyc=%0d got=%0d exp=%0d", cyc, err_cnt, m_cnt); end
            n_checks++; if (err_flag !== m_flag) begin n_fail++; $display("FAIL rnd_err_flag cyc=%0d got=%b exp=%b", cyc, err_flag, m_flag); end
            book();
        end
        n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL rnd_drain_timeout got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_monitor();
        // Clear, then a flagged beat whose delivery coincides with err_clr.
        step(0, 0, 0, 0, 0, 1, 1); book();
        step(0, 1, 4'd1, 4'd0, 1, 1, 0); book();
        step(0, 0, 0, 0, 0, 1, 0); book();
        step(0, 0, 0, 0, 0, 1, 1);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mon_clr_beat_valid got=%b exp=1", out_valid); end
        book();
        step(0, 0, 0, 0, 0, 1, 0);
        n_checks++; if (err_cnt !== '0) begin n_fail++; $display("FAIL mon_clr_wins got=%0d exp=0", err_cnt); end
        n_checks++; if (err_flag !== 1'b0) begin n_fail++; $display("FAIL mon_clr_flag got=%b exp=0", err_flag); end
        book();
        // Error equal to ET (2-0 approx: error 0) must not count.
        step(0, 1, 4'd2, 4'd0, 1, 1, 0); book();
        for (int i = 0; i < 3; i++) begin step(0, 0, 0, 0, 0, 1, 0); book(); end
        n_checks++; if (err_cnt !== '0) begin n_fail++; $display("FAIL mon_at_threshold got=%0d exp=0", err_cnt); end
        // Ten flagged beats back to back: counter saturates.
        for (int i = 0; i < 14; i++) begin
            step(0, i < 10, 4'd1, 4'd0, 1, 1, 0);
            n_checks++; if (err_cnt !== ERR_CNT_W'(m_cnt)) begin n_fail++; $display("FAIL mon_cnt i=%0d got=%0d exp=%0d", i, err_cnt, m_cnt); end
            book();
        end
        n_checks++; if (err_cnt !== ERR_CNT_W'(MON_EN ? CNT_MAX : 0)) begin n_fail++; $display("FAIL mon_saturate got=%0d exp=%0d", err_cnt, MON_EN ? CNT_MAX : 0); end
        n_checks++; if (err_flag !== MON_EN) begin n_fail++; $display("FAIL mon_sticky got=%b exp=%b", err_flag, MON_EN); end
    endtask

    task automatic test_reset_flush();
        step(0, 1, 4'd12, 4'd3, 0, 0, 0); book();
        step(0, 1, 4'd7, 4'd1, 1, 0, 0); book();
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 0);
        model_reset();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
        n_checks++; if (err_cnt !== '0) begin n_fail++; $display("FAIL flush_err_cnt got=%0d exp=0", err_cnt); end
        n_checks++; if (err_flag !== 1'b0) begin n_fail++; $display("FAIL flush_err_flag got=%b exp=0", err_flag); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 0, 0, 1, 0);
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_stale i=%0d got=%b exp=0", i, out_valid); end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random_stream();
        test_monitor();
        test_reset_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop in case a wait somewhere never returns.
    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
